// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: stores {parity_err, data},
// presents the head show-ahead, and raises level, timeout, overflow and parity status.
module uart_rx_fifo #(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_data,
   input  logic                     rx_parity_ok,
   input  logic                     drop_bad,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH):0]   thresh,
   input  logic                     status_clr,
   output logic                     rd_valid,
   output logic [7:0]               rd_data,
   output logic                     rd_parity_err,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     level_irq,
   output logic                     timeout_irq,
   output logic                     overflow,
   output logic [7:0]               err_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

   logic [8:0]    mem [DEPTH];
   logic [8:0]    head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [TW-1:0] tmo_cnt;
   logic [CW-1:0] count_nxt;
   logic          wr_ok;
   logic          push;
   logic          pop;
   logic          ovf_ev;
   logic          err_ev;

   assign rd_valid      = (count != '0);
   assign full          = (count == FULL_LVL);
   assign head          = mem[rd_ptr];
   assign rd_data       = rd_valid ? head[7:0] : '0;
   assign rd_parity_err = rd_valid & head[8];
   assign timeout_irq   = (tmo_cnt == TMO_MAX) & rd_valid;

   // A pop frees the slot in the same cycle, so a full FIFO still accepts a byte then.
   always_comb begin
      wr_ok     = rx_valid & ~(drop_bad & ~rx_parity_ok);
      pop       = rd_en & rd_valid;
      push      = wr_ok & (~full | pop);
      ovf_ev    = wr_ok & full & ~pop;
      err_ev    = rx_valid & ~rx_parity_ok;
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + 1'b1;
      end else if (pop && !push) begin
         count_nxt = count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {~rx_parity_ok, rx_data};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         level_irq <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count     <= count_nxt;
         // Registered against the post-edge occupancy to keep thresh off any output path.
         level_irq <= (thresh != '0) && (count_nxt >= thresh);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
         err_cnt  <= '0;
      end else begin
         if (ovf_ev) begin
            overflow <= 1'b1;
         end else if (status_clr) begin
            overflow <= 1'b0;
         end
         if (status_clr) begin
            err_cnt <= err_ev ? 8'd1 : 8'd0;
         end else if (err_ev && err_cnt != '1) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt <= '0;
      end else if (push || pop || !rd_valid) begin
         tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_MAX) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo: a queue-based reference model feeds a
// scoreboard that a negedge monitor drains on every consumer handshake.
module tb_uart_rx_fifo;

   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 1024;
   localparam int CW      = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_parity_ok;
   logic          drop_bad;
   logic          rd_en;
   logic [CW-1:0] thresh;
   logic          status_clr;
   logic          rd_valid;
   logic [7:0]    rd_data;
   logic          rd_parity_err;
   logic [CW-1:0] count;
   logic          full;
   logic          level_irq;
   logic          timeout_irq;
   logic          overflow;
   logic [7:0]    err_cnt;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .rx_parity_ok  (rx_parity_ok),
      .drop_bad      (drop_bad),
      .rd_en         (rd_en),
      .thresh        (thresh),
      .status_clr    (status_clr),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .rd_parity_err (rd_parity_err),
      .count         (count),
      .full          (full),
      .level_irq     (level_irq),
      .timeout_irq   (timeout_irq),
      .overflow      (overflow),
      .err_cnt       (err_cnt)
   );

   int tests = 0;
   int fails = 0;

   // Reference model state
   int         m_count  = 0;
   int         m_err    = 0;
   bit         m_ovf    = 1'b0;
   bit         m_level  = 1'b0;
   longint     edge_n   = 0;
   longint     last_act = 0;
   logic [8:0] sb_q[$];
   bit         mon_en   = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_count  = 0;
         m_err    = 0;
         m_ovf    = 1'b0;
         m_level  = 1'b0;
         last_act = edge_n;
         sb_q.delete();
      end else begin
         bit bad, elig, p_pop, p_push;
         edge_n++;
         bad    = rx_valid && !rx_parity_ok;
         elig   = rx_valid && !(drop_bad && bad);
         p_pop  = rd_en && (m_count > 0);
         p_push = elig && ((m_count < DEPTH) || p_pop);
         if (elig && m_count == DEPTH && !p_pop) m_ovf = 1'b1;
         else if (status_clr) m_ovf = 1'b0;
         if (status_clr) m_err = bad ? 1 : 0;
         else if (bad && m_err < 255) m_err++;
         if (p_push) sb_q.push_back({~rx_parity_ok, rx_data});
         m_count = m_count + int'(p_push) - int'(p_pop);
         if (p_push || p_pop) last_act = edge_n;
         m_level = (thresh != 0) && (m_count >= int'(thresh));
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         logic [8:0] exp_e;
         check("rd_valid", rd_valid, m_count > 0);
         check("count", count, m_count);
         check("full", full, m_count == DEPTH);
         check("level_irq", level_irq, m_level);
         check("timeout_irq", timeout_irq, (m_count > 0) && (edge_n - last_act >= TIMEOUT));
         check("overflow", overflow, m_ovf);
         check("err_cnt", err_cnt, m_err);
         if (m_count == 0) begin
            check("rd_data_empty", rd_data, 0);
            check("rd_perr_empty", rd_parity_err, 0);
         end else if (sb_q.size() > 0) begin
            exp_e = sb_q[0];
            check("head", {rd_parity_err, rd_data}, exp_e);
         end
         if (rd_en && rd_valid) begin
            if (sb_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL pop_data: got %0h expected no entry at %0t", {rd_parity_err, rd_data}, $time);
            end else begin
               exp_e = sb_q.pop_front();
               check("pop_data", {rd_parity_err, rd_data}, exp_e);
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [7:0] d, input logic pok,
                        input logic rd, input logic clr);
      rx_valid     = v;
      rx_data      = d;
      rx_parity_ok = pok;
      rd_en        = rd;
      status_clr   = clr;
      @(posedge clk);
      #1;
      rx_valid   = 1'b0;
      rd_en      = 1'b0;
      status_clr = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic drain();
      repeat (DEPTH + 1) drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      #5000000;
      fails++;
      $display("FAIL watchdog: got no finish expected finish by %0t", $time);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      rx_valid     = 1'b0;
      rx_data      = 8'h00;
      rx_parity_ok = 1'b1;
      drop_bad     = 1'b0;
      rd_en        = 1'b0;
      thresh       = '0;
      status_clr   = 1'b0;
      #3 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      mon_en = 1'b1;

      // single byte
      drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
      idle(1);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      idle(2);

      // fill, partial drain, refill across the pointer wrap
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      idle(1);
      repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      for (int i = 16; i < 20; i++) drive(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      drain();

      // overflow without pop, then accepted push with pop while full
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
      drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
      idle(1);
      drive(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
      idle(1);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      drain();

      // parity handling and status_clr coinciding with a bad byte
      drop_bad = 1'b0;
      drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
      drop_bad = 1'b1;
      drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
      drop_bad = 1'b0;
      idle(1);
      drain();

      // level and timeout
      thresh = CW'(4);
      for (int i = 0; i < 4; i++) drive(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      idle(TIMEOUT + 5);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      idle(3);
      drain();
      thresh = '0;

      // err_cnt saturation, then clear
      drop_bad = 1'b1;
      repeat (300) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      drop_bad = 1'b0;

      // randomized traffic in segments with varied rates and configuration
      for (int s = 0; s < 20; s++) begin
         int p_in, p_rd;
         p_in     = $urandom_range(10, 90);
         p_rd     = $urandom_range(10, 90);
         drop_bad = 1'($urandom);
         thresh   = CW'($urandom_range(0, DEPTH));
         for (int c = 0; c < 200; c++) begin
            drive(1'($urandom_range(0, 99) < p_in), 8'($urandom),
                  1'($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 99) < p_rd),
                  1'($urandom_range(0, 49) == 0));
         end
      end
      drop_bad = 1'b0;
      thresh   = '0;
      drain();

      // asynchronous reset mid-operation with count=7 and overflow set
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
      drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
      repeat (9) drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      check("pre_rst_count", count, 7);
      check("pre_rst_overflow", overflow, 1);
      #2 reset = 1'b0;
      #1;
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_rd_perr", rd_parity_err, 0);
      check("rst_count", count, 0);
      check("rst_full", full, 0);
      check("rst_level", level_irq, 0);
      check("rst_timeout", timeout_irq, 0);
      check("rst_overflow", overflow, 0);
      check("rst_err_cnt", err_cnt, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
      idle(1);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      idle(5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
